// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: shared op/state encodings and default width for the MIPS multiply/divide sequencer.
package mdu_sequencer_pkg;
  localparam int MDU_DATA_W = 32;
  localparam logic [1:0] MDU_OP_MULT  = 2'd0;
  localparam logic [1:0] MDU_OP_MULTU = 2'd1;
  localparam logic [1:0] MDU_OP_DIV   = 2'd2;
  localparam logic [1:0] MDU_OP_DIVU  = 2'd3;
  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} mdu_state_t;
  function automatic logic op_is_div(input logic [1:0] op);
    return !(op == MDU_OP_MULT || op == MDU_OP_MULTU);
  endfunction
  function automatic logic op_is_signed(input logic [1:0] op);
    return op == MDU_OP_MULT || op == MDU_OP_DIV;
  endfunction
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration on {acc, q}: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step #(
  parameter int W = 32
) (
  input  logic         div,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] q,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] acc_n,
  output logic [W-1:0] q_n
);
  logic [W:0]   sum;
  logic [W:0]   sh;
  logic [W-1:0] dif;
  logic         ge;
  assign sum = {1'b0, acc} + {1'b0, opnd};
  assign sh  = {acc, q[W-1]};
  assign ge  = sh >= {1'b0, opnd};
  // remainder stays below the divisor, so the true difference fits in W bits
  assign dif = sh[W-1:0] - opnd;
  always_comb begin
    acc_n = div ? (ge ? dif : sh[W-1:0]) : (q[0] ? sum[W:1] : {1'b0, acc[W-1:1]});
    q_n   = div ? {q[W-2:0], ge} : {q[0] ? sum[0] : acc[0], q[W-1:1]};
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, with decode stall.
// Define MDU_FAST_MUL_EN to compute multiplies in a single cycle (PREP -> FIX).
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  input  logic              hilo_rd,
  input  logic              hilo_wr,
  input  logic              hilo_wr_sel,
  input  logic [DATA_W-1:0] hilo_wr_data,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  mdu_state_t          state;
  logic                div_r;
  logic                sign_a;
  logic                sign_b;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   q;
  logic [DATA_W-1:0]   mop;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_n;
  logic [DATA_W-1:0]   q_n;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;
  assign abs_a  = sign_a ? -a_r : a_r;
  assign abs_b  = sign_b ? -b_r : b_r;
  assign prod_s = (sign_a ^ sign_b) ? -{acc, q} : {acc, q};
  assign res_hi = div_r ? (sign_a ? -acc : acc) : prod_s[2*DATA_W-1:DATA_W];
  assign res_lo = div_r ? ((sign_a ^ sign_b) ? -q : q) : prod_s[DATA_W-1:0];
  assign stall  = busy & (hilo_rd | hilo_wr | start);
`ifdef MDU_FAST_MUL_EN
  logic [2*DATA_W-1:0] prod_f;
  assign prod_f = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
`endif
  mdu_step #(.W(DATA_W)) u_step (
    .div  (div_r),
    .acc  (acc),
    .q    (q),
    .opnd (mop),
    .acc_n(acc_n),
    .q_n  (q_n)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      div_r  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      q      <= '0;
      mop    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hilo_wr && hilo_wr_sel) hi <= hilo_wr_data;
            if (hilo_wr && !hilo_wr_sel) lo <= hilo_wr_data;
            if (start) begin
              state  <= PREP;
              busy   <= 1'b1;
              div_r  <= op_is_div(op);
              a_r    <= src_a;
              b_r    <= src_b;
              sign_a <= op_is_signed(op) & src_a[DATA_W-1];
              sign_b <= op_is_signed(op) & src_b[DATA_W-1];
            end
          end
          PREP: begin
            acc <= '0;
            cnt <= CNT_W'(DATA_W);
            mop <= div_r ? abs_b : abs_a;
            q   <= div_r ? abs_a : abs_b;
            // divide by zero: results are unsigned-style, so drop the signs before FIX
            if (div_r && b_r == '0) begin
              q      <= '1;
              acc    <= abs_a;
              sign_a <= 1'b0;
              sign_b <= 1'b0;
              state  <= FIX;
              done   <= 1'b1;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!div_r) begin
              {acc, q} <= prod_f;
              state    <= FIX;
              done     <= 1'b1;
            end
`endif
            else state <= RUN;
          end
          RUN: begin
            acc <= acc_n;
            q   <= q_n;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= FIX;
              done  <= 1'b1;
            end
          end
          FIX: begin
            hi    <= res_hi;
            lo    <= res_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU issued from decode.
- Runs an iterative radix-2 engine and owns the architectural HI/LO registers.
- Drives a stall into decode when a later instruction touches HI/LO before the operation finishes.
- Sits beside the ALU in EX; decode ORs its stall output into the existing load-use stall.

Parameters:
- DATA_W, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue pulse for a multiply/divide op, one cycle.
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- src_a  in  DATA_W  rs operand (dividend / multiplicand).
- src_b  in  DATA_W  rt operand (divisor / multiplier).
- flush  in  1  squash the in-flight op.
- hilo_rd  in  1  decode holds MFHI/MFLO.
- hilo_wr  in  1  MTHI/MTLO write this cycle.
- hilo_wr_sel  in  1  target of hilo_wr: 0 LO, 1 HI.
- hilo_wr_data  in  DATA_W  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by an op.
- stall  out  1  hold decode.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:

Reset:
- Asynchronous on rst_n low. State IDLE; hi=0, lo=0, busy=0, done=0, stall=0; counter and working registers cleared.

States:
- IDLE:
  - start -> PREP. Latch op, src_a, src_b, and the signs for signed ops.
- PREP, 1 cycle:
  - Signed ops take absolute values.
  - Working remainder/product-high = 0.
  - Counter = DATA_W.
  - Divide with src_b==0 -> FIX directly, setting quotient = all ones and remainder = |src_a|.
- RUN, DATA_W cycles, counter decrements each cycle:
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter reaching 1 -> FIX.
- FIX, 1 cycle:
  - Signed multiply: negate the product if sign_a^sign_b.
  - Signed divide: quotient negated if sign_a^sign_b; remainder takes sign_a.
  - Write HI/LO: multiply gives HI = product[2W-1:W], LO = product[W-1:0]; divide gives HI = remainder, LO = quotient.
  - Assert done for this cycle only -> IDLE.

Timing:
- busy is high in PREP, RUN and FIX.
- Latency from the start cycle to the done cycle is DATA_W+2 = 34 cycles; HI/LO are visible the cycle after done.

Stall:
- stall = busy & (hilo_rd | hilo_wr | start).
- Decode holds the instruction, so the second start re-presents after completion.
- A start while busy is never accepted.

Flush:
- Any state -> IDLE next cycle. HI/LO unchanged, done not asserted.
- flush and start in the same IDLE cycle: flush wins, op is not latched.

hilo_wr:
- In IDLE: updates the selected register at the clock edge.
- When busy: ignored; stall holds it.
- In the same cycle as done cannot happen, because busy forces stall.

Corner cases:
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural wrap).
- Divide by zero results are defined above and identical for DIV and DIVU, using |src_a| for DIV.

Optional Feature:
- MDU_FAST_MUL_EN
- Defined: multiplies bypass RUN and use a single-cycle DATA_W x DATA_W multiplier. PREP then FIX, done 2 cycles after start. Divide is unchanged.
- Undefined: all ops iterate, 34-cycle latency.

Decomposition:
- Shared package/defines gain the MDU_OP_MULT/MULTU/DIV/DIVU encodings, MDU state encodings (IDLE/PREP/RUN/FIX) and the DATA_W default.
- One sub-module, mdu_step: a combinational single iteration (add-or-not / subtract-and-compare) on {acc, operand}.
- The FSM, counter, sign handling and HI/LO stay in mdu_sequencer.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle +34; HI=0xFFFFFFFE, LO=0x00000001; with MDU_FAST_MUL_EN, done at +2.
- DIV a=-7 (0xFFFFFFF9) b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100/7 -> LO=14, HI=2.
- DIVU a=0x12345678 b=0 -> LO=0xFFFFFFFF, HI=0x12345678, busy low afterward.
- MULT 3×-4 issued, hilo_rd raised the next cycle -> stall high until the done cycle; next cycle stall=0, LO=0xFFFFFFF4, HI=0xFFFFFFFF.
- Start DIVU, flush at cycle +10 -> busy drops next cycle, no done, HI/LO retain prior values (preload via MTHI=0xAAAA, MTLO=0x5555).
- rst_n asserted low mid-RUN (asynchronously, off clock edge) -> hi/lo/busy/stall/done all 0 immediately; operation resumes cleanly after release.
